// File: rtl/dma_regs.sv
// rtl/dma_regs.sv - CPU register file and start/completion sequencer for the DMA engine
// Optional feature: define DMA_IRQ_EN to drive irq from the done flag and CTRL bit0.
module dma_regs #(
  parameter int LAUNCH_TIMEOUT = 4,
  parameter int TMO_W          = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [2:0]  reg_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_rdy,
  output logic [7:0]  dma_ctrl,
  output logic [15:0] dma_src,
  output logic [15:0] dma_dst,
  output logic [7:0]  dma_length,
  input  logic        dma_busy,
  output logic        irq
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LAUNCH_TIMEOUT - 1);

  logic [15:0]      r_src;
  logic [15:0]      r_dst;
  logic [7:0]       r_len;
  logic [5:0]       r_ctrl_lo;
  logic [1:0]       r_state;
  logic [TMO_W-1:0] r_tmo;
  logic             r_timed_out;
  logic             r_done;
  logic             r_abort;

  logic       w_idle;
  logic       w_wr;
  logic       w_wr_ctrl;
  logic       w_rd_ctrl;
  logic       w_start;
  logic       w_clr;
  logic       w_set_done;
  logic       w_set_abort;
  logic       w_done_nxt;
  logic       w_abort_nxt;
  logic [5:0] w_ctrl_lo_nxt;

  // Register writes are only accepted in IDLE; the ack bit bypasses the lock.
  assign w_idle        = (r_state == S_IDLE);
  assign w_wr          = cs & cpu_we & w_idle;
  assign w_wr_ctrl     = cs & cpu_we & (reg_addr == 3'd5);
  assign w_rd_ctrl     = cs & ~cpu_we & (reg_addr == 3'd5);
  assign w_start       = w_wr_ctrl & w_idle & cpu_din[7];
  assign w_clr         = (w_wr_ctrl & cpu_din[6]) | w_rd_ctrl;
  assign w_set_done    = ((r_state == S_DONE) & ~r_timed_out) | (w_start & (r_len == 8'd0));
  assign w_set_abort   = (r_state == S_DONE) & r_timed_out;
  assign w_done_nxt    = w_set_done | (r_done & ~w_clr);
  assign w_abort_nxt   = w_set_abort | (r_abort & ~w_clr);
  assign w_ctrl_lo_nxt = (w_wr && reg_addr == 3'd5) ? cpu_din[5:0] : r_ctrl_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src       <= 16'h0000;
      r_dst       <= 16'h0000;
      r_len       <= 8'h00;
      r_ctrl_lo   <= 6'h00;
      r_state     <= S_IDLE;
      r_tmo       <= '0;
      r_timed_out <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_done    <= w_done_nxt;
      r_abort   <= w_abort_nxt;
      r_ctrl_lo <= w_ctrl_lo_nxt;
      if (w_wr) begin
        case (reg_addr)
          3'd0:    r_src[7:0]  <= cpu_din;
          3'd1:    r_src[15:8] <= cpu_din;
          3'd2:    r_dst[7:0]  <= cpu_din;
          3'd3:    r_dst[15:8] <= cpu_din;
          3'd4:    r_len       <= cpu_din;
          default: ;
        endcase
      end
      case (r_state)
        S_IDLE: begin
          if (w_start && r_len != 8'd0) begin
            r_state     <= S_LAUNCH;
            r_tmo       <= '0;
            r_timed_out <= 1'b0;
          end
        end
        S_LAUNCH: begin
          if (dma_busy) begin
            r_state <= S_RUN;
          end else if (r_tmo == TMO_LAST) begin
            r_state     <= S_DONE;
            r_timed_out <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_RUN: begin
          if (!dma_busy) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_dout = 8'hFF;
    case (reg_addr)
      3'd0:    cpu_dout = r_src[7:0];
      3'd1:    cpu_dout = r_src[15:8];
      3'd2:    cpu_dout = r_dst[7:0];
      3'd3:    cpu_dout = r_dst[15:8];
      3'd4:    cpu_dout = r_len;
      3'd5:    cpu_dout = {~w_idle, 5'b00000, r_abort, r_done};
      default: cpu_dout = 8'hFF;
    endcase
  end

  assign cpu_rdy    = w_idle;
  assign dma_ctrl   = {(r_state == S_LAUNCH) | (r_state == S_RUN), 1'b0, r_ctrl_lo};
  assign dma_src    = r_src;
  assign dma_dst    = r_dst;
  assign dma_length = r_len;

`ifdef DMA_IRQ_EN
  logic r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= w_done_nxt & w_ctrl_lo_nxt[0];
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif
endmodule
